// File: rtl/dma_block_copy.sv
// Bus-master DMA block copier: reads a word from src, writes it to dst, repeats len times.
// Optional macro DMA_SMEM_HOLDOFF_EN suppresses requests while pc is inside secure memory.
module dma_block_copy #(
  parameter logic [15:0] SMEM_BASE = 16'hE000,
  parameter logic [15:0] SMEM_SIZE = 16'h1000,
  parameter int          LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      pc,
  input  logic [15:0]      dma_dout,
  input  logic             dma_ready,
  input  logic             dma_resp,
  output logic             dma_en,
  output logic [1:0]       dma_we,
  output logic [15:0]      dma_addr,
  output logic [15:0]      dma_din,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       dbg_state
);

  // Handshake: an access completes in any cycle where dma_en && dma_ready;
  // until then dma_addr/dma_we/dma_din and all state hold unchanged.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cur_src_q, cur_src_d;
  logic [15:0]        cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [15:0]        buf_q, buf_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold;
  logic               hs;

`ifdef DMA_SMEM_HOLDOFF_EN
  logic [15:0] smem_last;
  assign smem_last = SMEM_BASE + SMEM_SIZE - 16'd2;
  assign hold      = (pc >= SMEM_BASE) && (pc <= smem_last);
`else
  logic unused_pc;
  assign unused_pc = ^{pc, SMEM_BASE, SMEM_SIZE};
  assign hold      = 1'b0;
`endif

  assign dma_en    = (state_q != IDLE) && !hold;
  assign hs        = dma_en && dma_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

  always_comb begin
    dma_we   = 2'b00;
    dma_addr = 16'h0000;
    dma_din  = 16'h0000;
    case (state_q)
      RD: dma_addr = cur_src_q;
      WR: begin
        dma_we   = 2'b11;
        dma_addr = cur_dst_q;
        dma_din  = buf_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    done_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (len != '0) begin
            cur_src_d   = src_addr & 16'hFFFE;
            cur_dst_d   = dst_addr & 16'hFFFE;
            remaining_d = len;
            state_d     = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (hs) begin
          if (dma_resp) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            buf_d   = dma_dout;
            state_d = WR;
          end
        end
      end
      WR: begin
        if (hs) begin
          if (dma_resp) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cur_src_d   = cur_src_q + 16'd2;
            cur_dst_d   = cur_dst_q + 16'd2;
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_src_q   <= 16'h0000;
      cur_dst_q   <= 16'h0000;
      remaining_q <= '0;
      buf_q       <= 16'h0000;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_dma_block_copy.sv
// Self-checking bench for dma_block_copy: memory responder, access log and a word-level copy model.
module tb_dma_block_copy;

`ifdef DMA_SMEM_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [15:0] src_addr, dst_addr, pc;
  logic [7:0]  len;
  logic [15:0] dma_dout;
  logic        dma_ready, dma_resp;
  logic        dma_en, busy, done, error;
  logic [1:0]  dma_we, dbg_state;
  logic [15:0] dma_addr, dma_din;

  dma_block_copy dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .pc(pc), .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp),
    .dma_en(dma_en), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- memory responder and access log ----------------
  logic [15:0] salt;
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  int          stall_n = 0;
  int          err_abs = -1;
  int          wait_cnt = 0;
  int          hs_idx = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_rec = '0;
  logic [33:0] cur_rec;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];

  function automatic logic [15:0] seed_word(input int i, input logic [15:0] s);
    return 16'(i * 40503) ^ s;
  endfunction

  assign dma_ready = (wait_cnt >= stall_n);
  assign dma_resp  = dma_ready && (hs_idx == err_abs);
  assign dma_dout  = mem[dma_addr[15:1]];
  assign cur_rec   = {dma_we, dma_addr, (dma_we == 2'b11) ? dma_din : 16'h0000};

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= 0;
      prev_stall <= 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] <= seed_word(i, salt);
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && dma_en && (cur_rec != prev_rec)) stall_viol <= stall_viol + 1;
      prev_stall <= dma_en && !dma_ready;
      prev_rec   <= cur_rec;
      if (dma_en && dma_ready) begin
        obs_q.push_back(cur_rec);
        hs_idx   <= hs_idx + 1;
        wait_cnt <= 0;
        if (dma_we == 2'b11 && !dma_resp) mem[dma_addr[15:1]] <= dma_din;
      end else if (dma_en) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [33:0] o, input logic [33:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 32768; i++) ref_mem[i] = seed_word(i, salt);
  endtask

  // One transfer: build the expected access list and memory image from the copy rules,
  // drive start, wait for done, then compare timing, flags, accesses and memory.
  task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input int n,
                          input int st, input int err, input int hold_at, input int hold_len,
                          input string tag);
    logic [15:0] s, d, v, a;
    int acc, exp_cyc, busy0, done0, cyc, m;
    logic exp_err;
    exp_q.delete();
    s = src & 16'hFFFE;
    d = dst & 16'hFFFE;
    acc = 0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({2'b00, s, 16'h0000});
      acc++;
      if (err == acc - 1) begin exp_err = 1'b1; break; end
      v = ref_mem[s[15:1]];
      exp_q.push_back({2'b11, d, v});
      acc++;
      if (err == acc - 1) begin exp_err = 1'b1; break; end
      ref_mem[d[15:1]] = v;
      s = s + 16'd2;
      d = d + 16'd2;
    end
    exp_cyc = (n == 0) ? 1 : acc * (1 + st) + 1 + ((HOLDOFF && hold_len > 0) ? hold_len : 0);

    @(negedge clk);
    stall_n  = st;
    err_abs  = (err >= 0) ? hs_idx + err : -1;
    busy0    = busy_cnt;
    done0    = done_cnt;
    obs_q.delete();
    src_addr = src;
    dst_addr = dst;
    len      = 8'(n);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (hold_len > 0 && cyc >= hold_at && cyc < hold_at + hold_len) begin
        pc = 16'hE010;
        #1;
        check({tag, "_hold_en"}, 34'(dma_en), 34'(!HOLDOFF));
      end else begin
        pc = 16'h4400;
      end
      @(negedge clk);
      cyc++;
    end
    pc = 16'h4400;
    check({tag, "_done_cycle"}, 34'(cyc), 34'(exp_cyc));
    check({tag, "_busy_at_done"}, 34'(busy), 34'(0));
    check({tag, "_error"}, 34'(error), 34'(exp_err));
    @(negedge clk);
    check({tag, "_done_width"}, 34'(done), 34'(0));
    check({tag, "_done_count"}, 34'(done_cnt - done0), 34'(1));
    check({tag, "_busy_cycles"}, 34'(busy_cnt - busy0), 34'(exp_cyc - 1));
    repeat (4) @(negedge clk);
    check({tag, "_access_count"}, 34'(obs_q.size()), 34'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_access"}, obs_q[i], exp_q[i]);
    for (int i = 0; i < n; i++) begin
      a = (dst & 16'hFFFE) + 16'(2 * i);
      check({tag, "_mem"}, {18'h0, mem[a[15:1]]}, {18'h0, ref_mem[a[15:1]]});
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] rs, rd;
    int rn, rst, rerr;
    salt     = 16'($urandom);
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = 16'h0000;
    dst_addr = 16'h0000;
    len      = 8'h00;
    pc       = 16'h4400;
    init_ref();
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'h0, dma_en, dma_we, dma_addr, busy, done, error},
          34'h0);
    check("reset_din", 34'(dma_din), 34'(0));
    reset = 1'b0;

    run_xfer(16'h0200, 16'h0300, 3, 0, -1, 0, 0, "basic");
    run_xfer(16'h0800, 16'h0900, 0, 0, -1, 0, 0, "len0");
    run_xfer(16'hFFFE, 16'h0400, 2, 3, -1, 0, 0, "wrap");
    run_xfer(16'h1000, 16'h2000, 4, 0, 3, 0, 0, "err_wr2");
    run_xfer(16'h1101, 16'h2101, 2, 1, -1, 0, 0, "after_err");
    run_xfer(16'h3000, 16'h3100, 4, 0, -1, 3, 5, "holdoff");

    // Reset while the first write of a len=5 transfer is outstanding
    @(negedge clk);
    src_addr = 16'h0500; dst_addr = 16'h0600; len = 8'd5; stall_n = 0; err_abs = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_reset_in_wr", 34'(dma_we), 34'(2'b11));
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {12'h0, dma_en, dma_we, dma_addr, busy, done, error}, 34'h0);
    check("mid_reset_din", 34'(dma_din), 34'(0));
    reset = 1'b0;
    init_ref();
    run_xfer(16'h0500, 16'h0600, 1, 0, -1, 0, 0, "post_reset");

    for (int k = 0; k < 6; k++) begin
      rs   = 16'($urandom);
      rd   = 16'($urandom);
      rn   = $urandom_range(1, 8);
      rst  = $urandom_range(0, 2);
      rerr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * rn - 1) : -1;
      run_xfer(rs, rd, rn, rst, rerr, 0, 0, "random");
    end

    check("stall_stability", 34'(stall_viol), 34'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
